custom_instrument_boxcar: RTL and testbench
===========================================

# custom_instrument_boxcar

Parametrised multi-channel triggered boxcar averager that plugs into the Moku Custom Instrument slot in place of the plain pass-through top. On each trigger (external edge or software bit) it waits a programmable delay, then accumulates 2^L samples on every channel and presents the arithmetic-shifted mean on the outputs. The mean is held until the next capture. Configuration comes from the 16-word control bank; capture state and results are reported on the 16-word status bank.

## Interface
- NCH, 4: channel count, 1..4.
- DATA_W, 16: sample width, signed.
- MAX_LOG2_LEN, 12: largest window exponent; accumulator width ACC_W = DATA_W+MAX_LOG2_LEN.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sync  in  32  ignored.
- din  in  NCH*DATA_W  packed signed samples; channel k at [k*DATA_W +: DATA_W].
- exttrig  in  1  external trigger level, synchronous to clk.
- dout  out  NCH*DATA_W  held signed means, same packing as din.
- dout_interp  out  NCH  tied 0.
- control  in  16x32  register bank.
- status  out  16x32  register bank.

## Operation
- control[0]: bit0 enable, bit1 sw_trig (rising edge), bit2 single_shot, bit3 clear_counts (level).
- control[1][3:0] = L, clamped to MAX_LOG2_LEN. control[2][15:0] = D, delay cycles.
- trig = (exttrig & ~exttrig_q) | (sw_trig & ~sw_trig_q); edge registers reset to 0.
- States: IDLE, ARMED, DELAY, ACCUM, DONE.
- IDLE -> ARMED on enable rising edge, or on reset release if enable is already 1.
- ARMED -> DELAY on trig, or ARMED -> ACCUM on trig when D=0. L and D are latched at this transition.
- DELAY -> ACCUM once D cycles have elapsed.
- ACCUM -> DONE after 2^L samples have been accumulated.
- DONE lasts one cycle, then goes to IDLE if single_shot, else to ARMED.
- enable=0 forces IDLE next cycle from any state; the partial accumulation is discarded and dout is unchanged.
- Accumulation: acc starts at sign-extended first sample, and every following sample adds to it. The result is acc >>> L (arithmetic shift, rounds toward -inf), truncated to DATA_W; the truncation is lossless by construction.
- A trig seen in DELAY, ACCUM or DONE increments missed_cnt and is otherwise ignored.
- Counters saturate at 0xFFFFFFFF and are zeroed while clear_counts=1.
- status[0][2:0] is the state code (IDLE=0, ARMED=1, DELAY=2, ACCUM=3, DONE=4). status[1] is done_cnt, status[2] is missed_cnt.
- status[3+k] is the channel k mean sign-extended to 32 bits for k<NCH. All other status words are 0.

## Timing
- Reset: state IDLE; acc, dout, done_cnt, missed_cnt and every status word are 0.
- Edge at cycle t0, meaning exttrig=1 at t0 and 0 at t0-1:
  - Samples are taken at t0+1+D .. t0+D+2^L.
  - State is DONE at t0+D+2^L+1; dout and status[3+k] update on that same edge.
  - done_cnt increments on that same edge.
- Earliest re-trigger is accepted at t0+D+2^L+2.
- Changes to L or D during a capture take effect at the next trigger.
- exttrig and sw_trig edges in the same cycle count as one trigger.
- trig coinciding with enable falling: enable wins and the trigger is dropped (not counted as missed).
- reset mid-capture: everything returns to its reset value on the next edge.

## Structure
- Package ci_boxcar_pkg holds:
  - the state enum;
  - control bit and field indices;
  - status word indices;
  - the DATA_W and MAX_LOG2_LEN defaults.
- Sub-module boxcar_channel, instantiated NCH times, contains one accumulator and the shift/hold register. Its inputs are sample, start, accumulate, commit and L. Its output is mean.
- The top holds the FSM, trigger edge detection, delay/window counter, the event counters and the status mux.

## Test plan
- NCH=4, L=2, D=0, din={100,-100,7,-8} constant, exttrig pulse at t0 -> dout={100,-100,7,-8} at t0+5, done_cnt=1.
- L=3, D=5, ramp din ch0=0..: sample window starts at t0+6 -> mean=(v(t0+6)+..+v(t0+13))>>>3, DONE at t0+14.
- Trigger again during ACCUM -> missed_cnt=1, done_cnt unchanged, DONE timing unchanged.
- L=1, ch0 samples -3,-2 -> mean=-3 (floor); L=12, all samples 0x7FFF -> 0x7FFF, no overflow.
- single_shot=1: two triggers 100 cycles apart -> one DONE, state 0 after; enable 0->1 -> ARMED, next trigger captures.
- enable dropped mid-ACCUM -> IDLE next cycle, dout retains previous value. Reset mid-DELAY -> all status 0 next cycle.

Source files
------------

// File: rtl/ci_boxcar_pkg.sv
// Shared definitions for the triggered boxcar averager: state codes, register-bank
// layout and default widths.
package ci_boxcar_pkg;

  localparam int DEFAULT_DATA_W       = 16;
  localparam int DEFAULT_MAX_LOG2_LEN = 12;

  localparam int CTRL_LEN_W   = 4;
  localparam int CTRL_DELAY_W = 16;

  // control word indices and control[0] bit positions
  localparam int CTRL_MODE  = 0;
  localparam int CTRL_LEN   = 1;
  localparam int CTRL_DELAY = 2;

  localparam int BIT_ENABLE  = 0;
  localparam int BIT_SW_TRIG = 1;
  localparam int BIT_SINGLE  = 2;
  localparam int BIT_CLEAR   = 3;

  // status word indices
  localparam int STAT_STATE      = 0;
  localparam int STAT_DONE_CNT   = 1;
  localparam int STAT_MISSED_CNT = 2;
  localparam int STAT_MEAN0      = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/boxcar_channel.sv
// One boxcar channel: signed accumulator plus the held, arithmetically shifted mean.
module boxcar_channel
  import ci_boxcar_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int MAX_LOG2_LEN = DEFAULT_MAX_LOG2_LEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_W-1:0]     sample,
  input  logic                         start,
  input  logic                         accumulate,
  input  logic                         commit,
  input  logic [CTRL_LEN_W-1:0]        l,
  output logic signed [DATA_W-1:0]     mean
);

  localparam int ACC_W = DATA_W + MAX_LOG2_LEN;

  logic signed [ACC_W-1:0]  acc_q, acc_d, sample_ext, shifted;
  logic signed [DATA_W-1:0] mean_q, mean_d;

  assign sample_ext = {{MAX_LOG2_LEN{sample[DATA_W-1]}}, sample};

  // The final sample and the commit share a cycle, so the mean is taken from acc_d.
  always_comb begin
    acc_d = acc_q;
    if (start) begin
      acc_d = sample_ext;
    end else if (accumulate) begin
      acc_d = acc_q + sample_ext;
    end
    shifted = acc_d >>> l;
    mean_d  = commit ? shifted[DATA_W-1:0] : mean_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      mean_q <= '0;
    end else begin
      acc_q  <= acc_d;
      mean_q <= mean_d;
    end
  end

  assign mean = mean_q;

endmodule

// File: rtl/custom_instrument_boxcar.sv
// Triggered multi-channel boxcar averager for the Custom Instrument slot: trigger
// detection, capture FSM, delay/window counting, event counters and status bank.
module custom_instrument_boxcar
  import ci_boxcar_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int MAX_LOG2_LEN = DEFAULT_MAX_LOG2_LEN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             sync,
  input  logic [NCH*DATA_W-1:0]   din,
  input  logic                    exttrig,
  output logic [NCH*DATA_W-1:0]   dout,
  output logic [NCH-1:0]          dout_interp,
  input  logic [31:0]             control [0:15],
  output logic [31:0]             status  [0:15]
);

  state_e state_q, state_d;
  logic exttrig_q, sw_trig_q, enable_q;
  logic [CTRL_LEN_W-1:0]   l_q, l_d, l_clamped;
  logic [CTRL_DELAY_W-1:0] d_q, d_d, cnt_q, cnt_d, win_len;
  logic [31:0] done_cnt_q, done_cnt_d, missed_cnt_q, missed_cnt_d;
  logic enable, sw_trig, single_shot, clear_counts, trig;
  logic start, accumulate, commit, missed_inc;
  logic signed [DATA_W-1:0] mean [NCH];
  logic unused_inputs;

  assign enable       = control[CTRL_MODE][BIT_ENABLE];
  assign sw_trig      = control[CTRL_MODE][BIT_SW_TRIG];
  assign single_shot  = control[CTRL_MODE][BIT_SINGLE];
  assign clear_counts = control[CTRL_MODE][BIT_CLEAR];
  assign trig = (exttrig & ~exttrig_q) | (sw_trig & ~sw_trig_q);
  assign l_clamped = (int'(control[CTRL_LEN][CTRL_LEN_W-1:0]) > MAX_LOG2_LEN) ?
                     CTRL_LEN_W'(MAX_LOG2_LEN) : control[CTRL_LEN][CTRL_LEN_W-1:0];
  assign win_len = CTRL_DELAY_W'(1) << l_q;

  always_comb begin
    unused_inputs = (^sync) ^ (^control[CTRL_MODE][31:4]) ^ (^control[CTRL_LEN][31:4]) ^
                    (^control[CTRL_DELAY][31:16]);
    for (int i = 3; i < 16; i++) begin
      unused_inputs = unused_inputs ^ (^control[i]);
    end
  end

  // cnt_q counts delay cycles in DELAY and sample index in ACCUM; enable low overrides all.
  always_comb begin
    state_d    = state_q;
    l_d        = l_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    start      = 1'b0;
    accumulate = 1'b0;
    commit     = 1'b0;
    missed_inc = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!enable_q) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (trig) begin
            l_d     = l_clamped;
            d_d     = control[CTRL_DELAY][CTRL_DELAY_W-1:0];
            cnt_d   = '0;
            state_d = (control[CTRL_DELAY][CTRL_DELAY_W-1:0] == '0) ? ST_ACCUM : ST_DELAY;
          end
        end
        ST_DELAY: begin
          missed_inc = trig;
          if (cnt_q == d_q - CTRL_DELAY_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            cnt_d = cnt_q + CTRL_DELAY_W'(1);
          end
        end
        ST_ACCUM: begin
          missed_inc = trig;
          start      = (cnt_q == '0);
          accumulate = (cnt_q != '0);
          if (cnt_q == win_len - CTRL_DELAY_W'(1)) begin
            commit  = 1'b1;
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CTRL_DELAY_W'(1);
          end
        end
        ST_DONE: begin
          missed_inc = trig;
          state_d    = single_shot ? ST_IDLE : ST_ARMED;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (clear_counts) begin
      done_cnt_d   = '0;
      missed_cnt_d = '0;
    end else begin
      done_cnt_d   = commit ? sat_inc(done_cnt_q) : done_cnt_q;
      missed_cnt_d = missed_inc ? sat_inc(missed_cnt_q) : missed_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      exttrig_q    <= 1'b0;
      sw_trig_q    <= 1'b0;
      enable_q     <= 1'b0;
      l_q          <= '0;
      d_q          <= '0;
      cnt_q        <= '0;
      done_cnt_q   <= '0;
      missed_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      exttrig_q    <= exttrig;
      sw_trig_q    <= sw_trig;
      enable_q     <= enable;
      l_q          <= l_d;
      d_q          <= d_d;
      cnt_q        <= cnt_d;
      done_cnt_q   <= done_cnt_d;
      missed_cnt_q <= missed_cnt_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    boxcar_channel #(
      .DATA_W       (DATA_W),
      .MAX_LOG2_LEN (MAX_LOG2_LEN)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .sample     (din[k*DATA_W +: DATA_W]),
      .start      (start),
      .accumulate (accumulate),
      .commit     (commit),
      .l          (l_q),
      .mean       (mean[k])
    );
    assign dout[k*DATA_W +: DATA_W] = mean[k];
  end

  assign dout_interp = '0;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      status[i] = '0;
    end
    status[STAT_STATE]      = {29'b0, state_q};
    status[STAT_DONE_CNT]   = done_cnt_q;
    status[STAT_MISSED_CNT] = missed_cnt_q;
    for (int k = 0; k < NCH; k++) begin
      status[STAT_MEAN0 + k] = 32'(mean[k]);
    end
  end

endmodule

// File: tb/tb_custom_instrument_boxcar.sv
// Self-checking bench for custom_instrument_boxcar: directed and random captures
// compared against an arithmetic model of window placement and floor-mean.
module tb_custom_instrument_boxcar;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int MAXL = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       sync;
  logic [NCH*DW-1:0] din;
  logic              exttrig;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    dout_interp;
  logic [31:0]       control [0:15];
  logic [31:0]       status  [0:15];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_done   = 0;
  int exp_missed = 0;
  logic [DW-1:0] exp_mean [NCH];

  custom_instrument_boxcar #(.NCH(NCH), .DATA_W(DW), .MAX_LOG2_LEN(MAXL)) dut (
    .clk         (clk),
    .reset       (reset),
    .sync        (sync),
    .din         (din),
    .exttrig     (exttrig),
    .dout        (dout),
    .dout_interp (dout_interp),
    .control     (control),
    .status      (status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_means(input string tag);
    for (int k = 0; k < NCH; k++) begin
      checkOutput($sformatf("%s_dout%0d", tag, k), 32'(dout[k*DW +: DW]), 32'(exp_mean[k]));
      checkOutput($sformatf("%s_stat%0d", tag, k), status[3+k], {{16{exp_mean[k][DW-1]}}, exp_mean[k]});
    end
  endtask

  task automatic check_counts(input string tag);
    checkOutput({tag, "_done_cnt"}, status[1], 32'(exp_done));
    checkOutput({tag, "_missed_cnt"}, status[2], 32'(exp_missed));
  endtask

  // mode 0 constant table, 1 ch0 ramp of cycle number, 3 ch0 = -3,-2,..., 4 full-scale, else random
  function automatic logic [DW-1:0] gen(input int mode, input int ch, input int c, input int ws);
    logic [DW-1:0] tbl [NCH];
    tbl[0] = 16'd100; tbl[1] = 16'(-100); tbl[2] = 16'd7; tbl[3] = 16'(-8);
    case (mode)
      0:       return tbl[ch];
      1:       return (ch == 0) ? 16'(c) : 16'($urandom);
      3:       return (ch == 0) ? 16'(c - ws - 3) : 16'($urandom);
      4:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One full capture from ARMED; src 0 ext, 1 sw, 2 both; retrig_off>=2 adds a late trigger.
  task automatic applyStimulus(input int l_ctrl, input int d, input int mode, input int src,
                               input int retrig_off);
    int l, t0, ws, we, done_at;
    longint sums [NCH];
    longint n, q;
    logic [DW-1:0] v;
    l = (l_ctrl > MAXL) ? MAXL : l_ctrl;
    control[1] = 32'(l_ctrl);
    control[2] = 32'(d);
    checkOutput("armed_before_trig", status[0], 32'd1);
    t0 = cyc;
    ws = t0 + d + 1;
    we = t0 + d + (1 << l);
    done_at = we + 1;
    for (int k = 0; k < NCH; k++) sums[k] = 0;
    while (cyc < done_at) begin
      for (int k = 0; k < NCH; k++) begin
        v = gen(mode, k, cyc, ws);
        din[k*DW +: DW] = v;
        if (cyc >= ws && cyc <= we) sums[k] += longint'($signed(v));
      end
      exttrig = (cyc == t0 && src != 1) || (retrig_off > 0 && cyc == t0 + retrig_off);
      control[0][1] = (cyc == t0 && src != 0);
      if (retrig_off > 0 && cyc == t0 + retrig_off) exp_missed++;
      tick();
      if (cyc < done_at) checkOutput("state_in_capture", status[0], (cyc < ws) ? 32'd2 : 32'd3);
    end
    exttrig = 1'b0;
    control[0][1] = 1'b0;
    exp_done++;
    n = longint'(1) << l;
    for (int k = 0; k < NCH; k++) begin
      q = sums[k] / n;
      if ((sums[k] % n) != 0 && sums[k] < 0) q = q - 1;
      exp_mean[k] = 16'(q);
    end
    checkOutput("state_done", status[0], 32'd4);
    check_means("capture");
    check_counts("capture");
    tick();
    checkOutput("state_after_done", status[0], control[0][2] ? 32'd0 : 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    sync = 32'hDEAD_BEEF;
    din = '0;
    exttrig = 1'b0;
    for (int i = 0; i < 16; i++) control[i] = '0;
    for (int k = 0; k < NCH; k++) exp_mean[k] = '0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) checkOutput($sformatf("reset_status%0d", i), status[i], 32'd0);
    checkOutput("reset_dout_lo", dout[31:0], 32'd0);
    checkOutput("reset_dout_hi", dout[63:32], 32'd0);
    checkOutput("dout_interp", 32'(dout_interp), 32'd0);

    // enable already high when reset releases
    control[0] = 32'h1;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("arm_on_reset_release", status[0], 32'd1);

    applyStimulus(2, 0, 0, 0, 0);
    checkOutput("const_ch0", 32'(dout[15:0]), 32'h0000_0064);
    checkOutput("const_ch1", 32'(dout[31:16]), 32'h0000_FF9C);
    applyStimulus(3, 5, 1, 0, 8);
    applyStimulus(1, 0, 3, 0, 0);
    checkOutput("floor_neg", 32'(dout[15:0]), 32'h0000_FFFD);
    for (int r = 0; r < 4; r++) begin
      applyStimulus($urandom_range(0, 5), $urandom_range(0, 7), 2, $urandom_range(0, 2), 0);
    end
    applyStimulus(2, 4, 2, 2, 2);
    applyStimulus(15, 0, 4, 0, 0);
    checkOutput("fullscale_ch3", 32'(dout[63:48]), 32'h0000_7FFF);

    // single shot: one capture, later trigger ignored, re-arm by enable toggle
    control[0][2] = 1'b1;
    applyStimulus(0, 2, 2, 0, 0);
    for (int i = 0; i < 100; i++) begin
      exttrig = (i == 50);
      tick();
    end
    exttrig = 1'b0;
    checkOutput("single_shot_idle", status[0], 32'd0);
    check_counts("single_shot");
    control[0][0] = 1'b0;
    tick();
    control[0][0] = 1'b1;
    control[0][2] = 1'b0;
    tick();
    checkOutput("rearm_on_enable", status[0], 32'd1);
    applyStimulus(2, 1, 2, 1, 0);

    // enable dropped mid-ACCUM with a coincident trigger
    control[1] = 32'd3;
    control[2] = 32'd0;
    din = {$urandom, $urandom};
    exttrig = 1'b1;
    tick();
    exttrig = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("mid_accum", status[0], 32'd3);
    control[0][0] = 1'b0;
    exttrig = 1'b1;
    tick();
    exttrig = 1'b0;
    checkOutput("enable_drop_idle", status[0], 32'd0);
    check_means("enable_drop");
    check_counts("enable_drop");
    control[0][0] = 1'b1;
    tick();
    checkOutput("rearm_after_drop", status[0], 32'd1);

    control[0][3] = 1'b1;
    tick();
    control[0][3] = 1'b0;
    exp_done = 0;
    exp_missed = 0;
    check_counts("clear");

    // reset in the middle of DELAY
    control[1] = 32'd2;
    control[2] = 32'd10;
    exttrig = 1'b1;
    tick();
    exttrig = 1'b0;
    tick();
    tick();
    checkOutput("mid_delay", status[0], 32'd2);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) checkOutput($sformatf("midreset_status%0d", i), status[i], 32'd0);
    checkOutput("midreset_dout_lo", dout[31:0], 32'd0);
    checkOutput("midreset_dout_hi", dout[63:32], 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("arm_after_midreset", status[0], 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
